// File: rtl/eight_bit_adder_if.sv
// Operand/result bundle for eight_bit_adder.
// Latency: none (wires only); the adder registers its result one edge later.
// Backpressure: none; the operands are sampled on every clock edge.
//
// Signals:
//   a, b      8-bit operands
//   Cin0      carry-in (add) / borrow-in (subtract) to bit 0
//   subtract  0 = add, 1 = subtract
//   C7        registered carry-out of bit 7 (for subtract, 1 = no borrow)
//   sum       registered result, modulo 256
interface eight_bit_adder_if;
  logic [7:0] a;
  logic [7:0] b;
  logic       Cin0;
  logic       subtract;
  logic       C7;
  logic [7:0] sum;

  // The master drives the operands and observes the result.
  modport master (
    output a, b, Cin0, subtract,
    input  C7, sum
  );

  // The adder consumes the operands and drives the result.
  modport slave (
    input  a, b, Cin0, subtract,
    output C7, sum
  );
endinterface

// File: rtl/eight_bit_adder.sv
// 8-bit ripple-carry adder/subtractor with registered carry-out and sum.
// Latency: 1 cycle; a new operation is accepted on every rising clk edge.
// Backpressure: none; inputs are sampled every edge and nothing can stall.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears C7 and sum immediately
//   bus    eight_bit_adder_if.slave (a, b, Cin0, subtract in; C7, sum out)
module eight_bit_adder (
  input  logic              clk,
  input  logic              reset,
  eight_bit_adder_if.slave  bus
);

  logic [7:0] w_b_eff;
  logic [7:0] w_s;
  logic       w_carry;
  logic       w_c8;

  logic       r_c7;
  logic [7:0] r_sum;

  // Ripple chain of eight full-adder cells. Subtraction reuses the same
  // chain as a + ~b + ~Cin0: inverting b and the carry-in is the two's-
  // complement trick, and it makes the carry-out read as "no borrow".
  // The carry is kept as a scalar walked bit by bit, so no vector bit of
  // the chain depends on another bit of the same vector.
  always_comb begin
    w_b_eff = bus.b ^ {8{bus.subtract}};
    w_s     = 8'h00;
    w_carry = bus.Cin0 ^ bus.subtract;
    for (int i = 0; i < 8; i++) begin
      w_s[i]  = bus.a[i] ^ w_b_eff[i] ^ w_carry;
      w_carry = (bus.a[i] & w_b_eff[i]) | (w_carry & (bus.a[i] ^ w_b_eff[i]));
    end
    w_c8 = w_carry;
  end

  // The result register. An asynchronous reset drops whatever result is in
  // flight; the first operands are then captured on the first edge after
  // reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c7  <= 1'b0;
      r_sum <= 8'h00;
    end else begin
      r_c7  <= w_c8;
      r_sum <= w_s;
    end
  end

  assign bus.C7  = r_c7;
  assign bus.sum = r_sum;

endmodule

// File: tb/tb_eight_bit_adder.sv
// Scoreboard bench for eight_bit_adder: the stimulus pushes expected
// results into a queue, and a monitor pops one entry after every rising
// edge for which a result is owed.
module tb_eight_bit_adder;

  logic clk;
  logic reset;

  eight_bit_adder_if bus_if ();

  eight_bit_adder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [8:0] exp;   // {C7, sum}
  } item_t;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model in plain integer arithmetic. Add gives the exact 9-bit
  // sum. Subtract gives the difference modulo 256, with C7 set exactly
  // when no borrow occurred (the difference is not negative).
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    int r;
    logic [8:0] res;
    if (!sub) begin
      r   = int'(a) + int'(b) + int'(cin);
      res = r[8:0];
    end else begin
      r   = int'(a) - int'(b) - int'(cin);
      res = {(r >= 0), r[7:0]};
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got C7=%0b sum=%02h, expected C7=%0b sum=%02h",
               name, got[8], got[7:0], exp[8], exp[7:0]);
    end
  endtask

  // Drive one operation on the falling edge and register its expected result.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub);
    item_t it;
    @(negedge clk);
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.Cin0     = cin;
    bus_if.subtract = sub;
    it.a   = a;
    it.b   = b;
    it.cin = cin;
    it.sub = sub;
    it.exp = model(a, b, cin, sub);
    exp_q.push_back(it);
  endtask

  // Monitor: each result appears one edge after its operands were driven.
  initial begin
    item_t it;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        nm = $sformatf("result a=%02h b=%02h cin=%0b sub=%0b", it.a, it.b, it.cin, it.sub);
        check(nm, {bus_if.C7, bus_if.sum}, it.exp);
      end
    end
  end

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still owed, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [7:0] da [7] = '{8'h02, 8'hFF, 8'hFF, 8'h05, 8'h03, 8'h05, 8'h00};
    logic [7:0] db [7] = '{8'h02, 8'h01, 8'hFF, 8'h03, 8'h05, 8'h03, 8'h00};
    logic       dc [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    logic       ds [7] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};

    reset           = 1'b1;
    bus_if.a        = 8'h00;
    bus_if.b        = 8'h00;
    bus_if.Cin0     = 1'b0;
    bus_if.subtract = 1'b0;

    #1;
    check("reset_initial", {bus_if.C7, bus_if.sum}, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {bus_if.C7, bus_if.sum}, 9'h000);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases, back to back; the last one (0 - 0 - 1) borrows out.
    for (int i = 0; i < 7; i++) issue(da[i], db[i], dc[i], ds[i]);
    drain();

    // Random stream, one operation per cycle.
    for (int i = 0; i < 1000; i++)
      issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Reset between edges with 80 + 80 pending: the in-flight result is lost.
    @(negedge clk);
    bus_if.a        = 8'h80;
    bus_if.b        = 8'h80;
    bus_if.Cin0     = 1'b0;
    bus_if.subtract = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_midcycle", {bus_if.C7, bus_if.sum}, 9'h000);
    @(posedge clk);
    #1;
    check("reset_over_edge", {bus_if.C7, bus_if.sum}, 9'h000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_released_before_edge", {bus_if.C7, bus_if.sum}, 9'h000);
    begin
      item_t it;
      it.a   = 8'h80;
      it.b   = 8'h80;
      it.cin = 1'b0;
      it.sub = 1'b0;
      it.exp = model(8'h80, 8'h80, 1'b0, 1'b0);
      exp_q.push_back(it);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
